issue_sequencer: RTL
====================

// Module: issue_sequencer
// PURPOSE
//   In-order issue controller between instruction fetch and the load/execute/save pipeline.
//   Fetches by PC and tracks pending destination addresses in a registered scoreboard.
//   Stalls on RAW/WAW hazards or when the in-flight limit is reached; otherwise issues one
//   instruction to the load stage. Frees scoreboard entries on save-stage writeback.
//   Raises executed once the program has ended and the pipeline has drained.
// PARAMETERS
//   INS_MEM_SIZE   32  instruction memory depth; IW = $clog2(INS_MEM_SIZE)
//   DATA_MEM_SIZE  64  data memory depth; scoreboard bits; DW = $clog2(DATA_MEM_SIZE)
//   OP_W           3   opcode width, passed through unchanged
//   MAX_INFLIGHT   4   max issued-but-not-written-back instructions (>=1)
// PORTS
//   clk          in   1     rising-edge clock
//   reset        in   1     reset, asynchronous, active-low
//   start        in   1     one-cycle pulse: run program from pc 0 (honoured in IDLE/DONE only)
//   pc           out  IW    fetch address
//   ins_valid    in   1     fetch word for current pc is valid
//   ins_last     in   1     word is the halt marker (never issued)
//   ins_op       in   OP_W  opcode
//   ins_src1     in   DW    source 1 address
//   ins_src2     in   DW    source 2 address
//   ins_dst      in   DW    destination address
//   iss_valid    out  1     issue request to load stage
//   iss_ready    in   1     load stage accepts
//   iss_op, iss_src1, iss_src2, iss_dst  out  OP_W/DW/DW/DW  latched instruction fields
//   wb_valid     in   1     save stage has written wb_addr
//   wb_addr      in   DW    written address
//   busy         out  1     high in FETCH/CHECK/ISSUE/DRAIN
//   executed     out  1     program complete and pipeline empty
//   stall_cnt    out  16    CHECK cycles lost to hazards; saturates at 16'hFFFF; cleared on start
//   proto_err    out  1     sticky: wb_valid received for an address with scoreboard bit clear
// BEHAVIOUR
//   Reset (async, active-low): state=IDLE, pc=0, scoreboard=0, inflight=0, and all outputs 0.
//   States:
//     IDLE   start -> FETCH; pc=0; stall_cnt=0; proto_err=0.
//     FETCH  wait ins_valid.
//              ins_last=1 -> DRAIN.
//              Otherwise latch op/src1/src2/dst into iss_* regs -> CHECK.
//     CHECK  hazard = sb[src1] | sb[src2] | sb[dst] | (inflight==MAX_INFLIGHT).
//              hazard=1 -> stay in CHECK; stall_cnt+1.
//              hazard=0 -> ISSUE; iss_valid=1 from the next edge.
//     ISSUE  iss_valid and iss_* held stable until iss_ready.
//              Handshake edge: sb[dst]=1; inflight+1; pc+1.
//              Next state: FETCH, or DRAIN if pc was INS_MEM_SIZE-1 (no wrap; implicit halt).
//              iss_valid falls on the handshake edge.
//     DRAIN  wait inflight==0 -> DONE.
//     DONE   executed=1; start -> FETCH (pc=0, executed=0).
//   Scoreboard and inflight are registered; no bypass.
//     wb_valid at edge t clears sb[wb_addr] and decrements inflight from t.
//     A stalled instruction waiting on that address issues (iss_valid=1) from edge t+1.
//   Writeback is accepted in every state except IDLE.
//   Simultaneous issue handshake and wb_valid: inflight unchanged.
//     Both bit updates apply (addresses necessarily differ, by the WAW check).
//   wb_valid with sb[wb_addr]=0: ignored (no bit change, no decrement); proto_err=1.
//   Minimum issue interval: 3 cycles (FETCH, CHECK, ISSUE with iss_ready=1).
//   start while busy: ignored.
//   Reset mid-operation: all state lost immediately; in-flight writebacks after release are
//     flagged as proto_err only once a new run has started (IDLE ignores wb).
// STRUCTURE
//   Shared package seq_pkg: state encoding localparams (IDLE, FETCH, CHECK, ISSUE, DRAIN, DONE),
//     STALL_W=16.
//   Sub-module issue_scoreboard: DATA_MEM_SIZE-bit bitmap, inflight counter, set/clear ports,
//     three read ports (src1/src2/dst), full flag.
//   FSM, pc and stall counter live in the top module.
// TESTING
//   1. Independent: ADD m2<-m0,m1; ADD m5<-m3,m4; halt; iss_ready=1; wb 2 cycles after issue
//      -> issues 3 cycles apart, stall_cnt=0, executed=1 after last wb, pc=2.
//   2. RAW: m2<-m0,m1 then m3<-m2,m0; wb for m2 delayed 10 cycles
//      -> second iss_valid rises exactly 1 cycle after wb edge; stall_cnt>=9.
//   3. WAW: two writes to m7 -> second waits for wb_addr=7.
//   4. Full: MAX_INFLIGHT=4, 5 independent instructions, no wb
//      -> 4 issue, 5th stalls until any wb, then issues next cycle.
//   5. Backpressure: iss_ready low 5 cycles -> iss_* stable, pc unchanged; then one handshake.
//   6. Corners: wb_valid to clean address -> proto_err=1, inflight unchanged.
//      Reset asserted in ISSUE -> all outputs 0 asynchronously.
//      32 instructions with no halt -> DRAIN after pc=31, pc never wraps.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the issue sequencer: FSM state encoding, stall
// counter width and a saturating increment helper.
package seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t FETCH = 3'd1;
    localparam state_t CHECK = 3'd2;
    localparam state_t ISSUE = 3'd3;
    localparam state_t DRAIN = 3'd4;
    localparam state_t DONE  = 3'd5;

    localparam int STALL_W = 16;

    // Increment that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-destination scoreboard: one bit per data address plus a count of
// issued-but-not-written-back instructions. Set on issue, cleared on
// writeback; a writeback to a clean address is reported and otherwise ignored.
module issue_scoreboard #(
    parameter int DATA_MEM_SIZE = 64,
    parameter int MAX_INFLIGHT  = 4,
    parameter int DW            = $clog2(DATA_MEM_SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_en,
    input  logic [DW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [DW-1:0] clr_addr,
    input  logic [DW-1:0] rd_addr1,
    input  logic [DW-1:0] rd_addr2,
    input  logic [DW-1:0] rd_addr3,
    output logic          rd_bit1,
    output logic          rd_bit2,
    output logic          rd_bit3,
    output logic          clr_err,
    output logic          full,
    output logic          empty
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic [DATA_MEM_SIZE-1:0] sb;
    logic [CW-1:0]            inflight;
    logic                     clr_ok;

    // A writeback only counts if its address is actually pending.
    assign clr_ok  = clr_en && sb[clr_addr];
    assign clr_err = clr_en && !sb[clr_addr];

    assign rd_bit1 = sb[rd_addr1];
    assign rd_bit2 = sb[rd_addr2];
    assign rd_bit3 = sb[rd_addr3];

    assign full  = (inflight == CW'(MAX_INFLIGHT));
    assign empty = (inflight == '0);

    // Bitmap update: clear the written-back address, mark the issued destination.
    // NOTE: the bitmap is a bank of flops rather than a RAM, so it is reset like
    // any register; a stale set bit after reset would stall the first run forever.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb <= '0;
        end else begin
            if (clr_ok) sb[clr_addr] <= 1'b0;
            if (set_en) sb[set_addr] <= 1'b1;
        end
    end

    // In-flight count: issue and accepted writeback in the same cycle cancel out.
    // NOTE: non-blocking assignments keep every flop reading pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
        end else if (set_en && !clr_ok) begin
            inflight <= inflight + 1'b1;
        end else if (clr_ok && !set_en) begin
            inflight <= inflight - 1'b1;
        end
    end

endmodule

// File: rtl/issue_sequencer.sv
// In-order issue controller. Fetches by pc, holds the fetched instruction in
// the iss_* registers, stalls on RAW/WAW hazards or a full in-flight window,
// and hands one instruction at a time to the load stage. Signals executed
// once the halt marker has been seen and every issued write has come back.
module issue_sequencer
    import seq_pkg::*;
#(
    parameter int  INS_MEM_SIZE  = 32,
    parameter int  DATA_MEM_SIZE = 64,
    parameter int  OP_W          = 3,
    parameter int  MAX_INFLIGHT  = 4,
    localparam int IW            = $clog2(INS_MEM_SIZE),
    localparam int DW            = $clog2(DATA_MEM_SIZE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [IW-1:0]      pc,
    input  logic               ins_valid,
    input  logic               ins_last,
    input  logic [OP_W-1:0]    ins_op,
    input  logic [DW-1:0]      ins_src1,
    input  logic [DW-1:0]      ins_src2,
    input  logic [DW-1:0]      ins_dst,
    output logic               iss_valid,
    input  logic               iss_ready,
    output logic [OP_W-1:0]    iss_op,
    output logic [DW-1:0]      iss_src1,
    output logic [DW-1:0]      iss_src2,
    output logic [DW-1:0]      iss_dst,
    input  logic               wb_valid,
    input  logic [DW-1:0]      wb_addr,
    output logic               busy,
    output logic               executed,
    output logic [STALL_W-1:0] stall_cnt,
    output logic               proto_err
);

    state_t state;
    state_t state_next;

    logic sb_src1;
    logic sb_src2;
    logic sb_dst;
    logic sb_full;
    logic sb_empty;
    logic clr_err;
    logic hazard;
    logic handshake;
    logic honour_start;
    logic wb_en;
    logic pc_last;
    logic fetch_take;

    // Start only restarts an idle or finished sequencer; IDLE ignores writebacks.
    assign honour_start = start && ((state == IDLE) || (state == DONE));
    assign handshake    = (state == ISSUE) && iss_ready;
    assign wb_en        = wb_valid && (state != IDLE);
    assign pc_last      = (pc == IW'(INS_MEM_SIZE - 1));
    assign fetch_take   = (state == FETCH) && ins_valid && !ins_last;
    assign hazard       = sb_src1 | sb_src2 | sb_dst | sb_full;

    issue_scoreboard #(
        .DATA_MEM_SIZE (DATA_MEM_SIZE),
        .MAX_INFLIGHT  (MAX_INFLIGHT),
        .DW            (DW)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (handshake),
        .set_addr (iss_dst),
        .clr_en   (wb_en),
        .clr_addr (wb_addr),
        .rd_addr1 (iss_src1),
        .rd_addr2 (iss_src2),
        .rd_addr3 (iss_dst),
        .rd_bit1  (sb_src1),
        .rd_bit2  (sb_src2),
        .rd_bit3  (sb_dst),
        .clr_err  (clr_err),
        .full     (sb_full),
        .empty    (sb_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so every path drives state_next; no latch.
        state_next = state;
        case (state)
            IDLE, DONE: if (start)      state_next = FETCH;
            FETCH:      if (ins_valid)  state_next = ins_last ? DRAIN : CHECK;
            CHECK:      if (!hazard)    state_next = ISSUE;
            ISSUE:      if (iss_ready)  state_next = pc_last ? DRAIN : FETCH;
            DRAIN:      if (sb_empty)   state_next = DONE;
            default:                    state_next = IDLE;
        endcase
    end

    // Moore outputs decoded from the state.
    always_comb begin
        busy      = 1'b0;
        executed  = 1'b0;
        iss_valid = 1'b0;
        case (state)
            FETCH, CHECK, DRAIN: busy = 1'b1;
            ISSUE: begin
                busy      = 1'b1;
                iss_valid = 1'b1;
            end
            DONE:    executed = 1'b1;
            default: ;
        endcase
    end

    // Program counter: advances on each handshake and sticks at the last slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    pc <= '0;
        else if (honour_start)         pc <= '0;
        else if (handshake && !pc_last) pc <= pc + 1'b1;
    end

    // Instruction latch: captured in FETCH, held through CHECK and ISSUE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iss_op   <= '0;
            iss_src1 <= '0;
            iss_src2 <= '0;
            iss_dst  <= '0;
        end else if (fetch_take) begin
            iss_op   <= ins_op;
            iss_src1 <= ins_src1;
            iss_src2 <= ins_src2;
            iss_dst  <= ins_dst;
        end
    end

    // Hazard stall counter, cleared at the start of each run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          stall_cnt <= '0;
        else if (honour_start)               stall_cnt <= '0;
        else if ((state == CHECK) && hazard) stall_cnt <= sat_inc(stall_cnt);
    end

    // Sticky protocol error: a new run starts with a clean flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)            proto_err <= 1'b0;
        else if (honour_start) proto_err <= 1'b0;
        else if (clr_err)      proto_err <= 1'b1;
    end

endmodule
